// File: rtl/pgm_video_pkg.sv
// Shared constants and types for the PGM video pipeline.
// TX layer FSM states, attribute and pixel formats.
package pgm_video_pkg;

    localparam int         SCREEN_W       = 448;
    localparam int         TILES_PER_LINE = 57;
    localparam logic [13:0] TX_BASE       = 14'h2000;
    localparam logic [3:0] TRANSP_PEN     = 4'hF;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_FETCH0,
        TX_FETCH1,
        TX_ATTR,
        TX_GREQ,
        TX_GWAIT,
        TX_WRITE
    } tx_state_t;

    // Matches attribute word bits [7:1].
    typedef struct packed {
        logic       flipy;
        logic       flipx;
        logic [4:0] palette;
    } tx_attr_t;

    typedef struct packed {
        logic [4:0] pal;
        logic [3:0] pen;
    } tx_pix_t;

endpackage

// File: rtl/pgm_line_buffer.sv
// Ping-pong scanline buffer: 2 banks x 512 x 9 bits.
// One write port (render bank), one registered read port (display bank).
module pgm_line_buffer
    import pgm_video_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_wr_en,
    input  logic       i_wr_bank,
    input  logic [8:0] i_wr_addr,
    input  tx_pix_t    i_wr_data,
    input  logic       i_rd_bank,
    input  logic [8:0] i_rd_addr,
    output tx_pix_t    o_rd_data
);

    logic [8:0] r_mem [0:1023];
    logic [8:0] r_rd;

    always_ff @(posedge i_clk) begin
        if (i_wr_en)
            r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
        r_rd <= r_mem[{i_rd_bank, i_rd_addr}];
    end

    assign o_rd_data = tx_pix_t'(r_rd);

endmodule

// File: rtl/pgm_tx_line_renderer.sv
// PGM text-layer scanline renderer: tilemap walk, gfx ROM fetch, line buffer.
// Define TX_FLIP_EN to honour the flipx/flipy attribute bits.
module pgm_tx_line_renderer
    import pgm_video_pkg::*;
#(
    parameter int GFX_AW = 22
) (
    input  logic              fixed_20m_clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic [8:0]        line_num,
    input  logic [8:0]        scroll_x,
    input  logic [8:0]        scroll_y,
    output logic [13:0]       vram_addr,
    input  logic [15:0]       vram_dout,
    output logic              gfx_req,
    output logic [GFX_AW-1:0] gfx_addr,
    input  logic              gfx_ack,
    input  logic [31:0]       gfx_data,
    input  logic [8:0]        pix_x,
    output logic [8:0]        pix_out,
    output logic              busy,
    output logic              line_done
);

    tx_state_t   r_state, w_next;
    logic [4:0]  r_tile_row;
    logic [2:0]  r_pix_row;
    logic [5:0]  r_col0;
    logic [2:0]  r_fine;
    logic [5:0]  r_i;
    logic [2:0]  r_p;
    logic [15:0] r_code;
    logic [4:0]  r_pal;
    logic [31:0] r_data;
    logic        r_disp;
    logic [1:0]  r_valid;
    logic        r_line_done;
    logic        r_stale;
    logic        r_force;

    logic [7:0]  w_ty;
    logic [5:0]  w_tcol;
    logic [13:0] w_entry;
    logic [2:0]  w_row;
    logic [2:0]  w_nib;
    logic [10:0] w_x;
    logic        w_wr_en;
    logic        w_take;
    logic        w_last;
    tx_pix_t     w_wr_pix;
    tx_pix_t     w_rd_pix;
    logic        w_unused;

`ifdef TX_FLIP_EN
    logic     r_flipx, r_flipy;
    tx_attr_t w_attr;
    assign w_attr = tx_attr_t'(vram_dout[7:1]);
    assign w_row  = r_flipy ? ~r_pix_row : r_pix_row;
    assign w_nib  = r_flipx ? ~r_p : r_p;
`else
    assign w_row  = r_pix_row;
    assign w_nib  = r_p;
`endif

    assign w_unused = ^{line_num[8], scroll_y[8]};
    assign w_ty     = line_num[7:0] + scroll_y[7:0];
    assign w_tcol   = r_col0 + r_i;
    assign w_entry  = TX_BASE + {2'b00, r_tile_row, w_tcol, 1'b0};
    assign w_last   = (r_i == 6'(TILES_PER_LINE - 1));

    // Buffer x = i*8 + p - fine; negative results wrap to bit 10 set.
    assign w_x      = {2'b00, r_i, r_p} - {8'd0, r_fine};
    assign w_wr_en  = (r_state == TX_WRITE) && !w_x[10]
                      && (w_x[9:0] < 10'(SCREEN_W));
    assign w_wr_pix = '{pal: r_pal, pen: r_data[{w_nib, 2'b00} +: 4]};

    assign gfx_req  = ((r_state == TX_GREQ) && !r_stale)
                      || (r_state == TX_GWAIT);
    assign gfx_addr = GFX_AW'({r_code, w_row, 2'b00});
    assign w_take   = gfx_req && gfx_ack;
    assign busy     = (r_state != TX_IDLE);
    assign line_done = r_line_done;
    assign pix_out  = r_force ? {5'd0, TRANSP_PEN} : w_rd_pix;

    always_comb begin
        w_next    = r_state;
        vram_addr = '0;
        unique case (r_state)
            TX_IDLE:   w_next = TX_IDLE;
            TX_FETCH0: begin
                vram_addr = w_entry;
                w_next    = TX_FETCH1;
            end
            TX_FETCH1: begin
                vram_addr = w_entry + 14'd1;
                w_next    = TX_ATTR;
            end
            TX_ATTR:   w_next = TX_GREQ;
            TX_GREQ:   if (!r_stale)
                           w_next = gfx_ack ? TX_WRITE : TX_GWAIT;
            TX_GWAIT:  if (gfx_ack) w_next = TX_WRITE;
            TX_WRITE:  if (r_p == 3'd7)
                           w_next = w_last ? TX_IDLE : TX_FETCH0;
            default:   w_next = TX_IDLE;
        endcase
        if (line_start)
            w_next = TX_FETCH0;
    end

    always_ff @(posedge fixed_20m_clk) begin
        if (reset) begin
            r_state     <= TX_IDLE;
            r_tile_row  <= '0;
            r_pix_row   <= '0;
            r_col0      <= '0;
            r_fine      <= '0;
            r_i         <= '0;
            r_p         <= '0;
            r_code      <= '0;
            r_pal       <= '0;
            r_data      <= '0;
            r_disp      <= 1'b0;
            r_valid     <= 2'b00;
            r_line_done <= 1'b0;
            r_stale     <= 1'b0;
            r_force     <= 1'b1;
`ifdef TX_FLIP_EN
            r_flipx     <= 1'b0;
            r_flipy     <= 1'b0;
`endif
        end else begin
            r_state     <= w_next;
            r_line_done <= 1'b0;
            // An ack still owed to a dropped request is ignored once.
            r_stale     <= line_start && gfx_req && !gfx_ack;
            r_force     <= !r_valid[r_disp] || (pix_x >= 9'(SCREEN_W));
            if (line_start) begin
                r_disp          <= ~r_disp;
                r_valid[r_disp] <= 1'b0;
                r_tile_row      <= w_ty[7:3];
                r_pix_row       <= w_ty[2:0];
                r_col0          <= scroll_x[8:3];
                r_fine          <= scroll_x[2:0];
                r_i             <= '0;
                r_p             <= '0;
            end else begin
                if (r_state == TX_FETCH1)
                    r_code <= vram_dout;
                if (r_state == TX_ATTR) begin
`ifdef TX_FLIP_EN
                    r_pal   <= w_attr.palette;
                    r_flipx <= w_attr.flipx;
                    r_flipy <= w_attr.flipy;
`else
                    r_pal   <= vram_dout[5:1];
`endif
                end
                if (w_take) begin
                    r_data <= gfx_data;
                    r_p    <= '0;
                end
                if (r_state == TX_WRITE) begin
                    r_p <= r_p + 3'd1;
                    if (r_p == 3'd7) begin
                        if (w_last) begin
                            r_valid[~r_disp] <= 1'b1;
                            r_line_done      <= 1'b1;
                        end else begin
                            r_i <= r_i + 6'd1;
                        end
                    end
                end
            end
        end
    end

    pgm_line_buffer u_lbuf (
        .i_clk     (fixed_20m_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_bank (~r_disp),
        .i_wr_addr (w_x[8:0]),
        .i_wr_data (w_wr_pix),
        .i_rd_bank (r_disp),
        .i_rd_addr (pix_x),
        .o_rd_data (w_rd_pix)
    );

endmodule
